// File: rtl/mpu_matrix_loader.sv
// Writer side of the MPU packed-matrix interface: packs a row-major element stream into a DIMxDIM bus.
// Optional mid-load idle timeout is enabled by defining MPU_LOADER_TIMEOUT_EN.
module mpu_matrix_loader #(
    parameter int DIM    = 5,
    parameter int ELEM_W = 8
`ifdef MPU_LOADER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [7:0]                size_in,
    input  logic                      elem_valid,
    input  logic [ELEM_W-1:0]         elem_data,
    output logic                      elem_ready,
    output logic [0:DIM*DIM*ELEM_W-1] matrix,
    output logic [7:0]                size,
    output logic                      matrix_valid,
    input  logic                      matrix_ack,
    output logic                      busy,
    output logic                      error
);

    localparam int MAT_W = DIM * DIM * ELEM_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [0:MAT_W-1] matrix_q, matrix_d;
    logic [7:0]       size_q, size_d;
    logic [7:0]       row_q, row_d;
    logic [7:0]       col_q, col_d;
    logic             error_q, error_d;
    logic             xfer;
    logic             last_col;
    logic             last_row;

`ifdef MPU_LOADER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] idle_q, idle_d;
`endif

    always_comb begin
        state_d  = state_q;
        matrix_d = matrix_q;
        size_d   = size_q;
        row_d    = row_q;
        col_d    = col_q;
        error_d  = 1'b0;
`ifdef MPU_LOADER_TIMEOUT_EN
        idle_d   = idle_q;
`endif
        xfer     = (state_q == LOAD) && elem_valid;
        last_col = (col_q == size_q - 8'd1);
        last_row = (row_q == size_q - 8'd1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((size_in != 8'd0) && (size_in <= 8'(DIM))) begin
                        matrix_d = '0;
                        size_d   = size_in;
                        row_d    = 8'd0;
                        col_d    = 8'd0;
                        state_d  = LOAD;
`ifdef MPU_LOADER_TIMEOUT_EN
                        idle_d   = '0;
`endif
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    // Constant-index write keeps the element decode a plain mux per slot.
                    for (int r = 0; r < DIM; r++) begin
                        for (int c = 0; c < DIM; c++) begin
                            if ((row_q == 8'(r)) && (col_q == 8'(c))) begin
                                matrix_d[(r*DIM+c)*ELEM_W +: ELEM_W] = elem_data;
                            end
                        end
                    end
                    if (last_col) begin
                        col_d = 8'd0;
                        row_d = row_q + 8'd1;
                        if (last_row) begin
                            state_d = DONE;
                        end
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                end
`ifdef MPU_LOADER_TIMEOUT_EN
                // A stalled source abandons the load and drops the partial matrix.
                if (xfer) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                    idle_d   = '0;
                    error_d  = 1'b1;
                    matrix_d = '0;
                    size_d   = 8'd0;
                    state_d  = IDLE;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
`endif
            end
            DONE: begin
                if (matrix_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            matrix_q <= '0;
            size_q   <= 8'd0;
            row_q    <= 8'd0;
            col_q    <= 8'd0;
            error_q  <= 1'b0;
`ifdef MPU_LOADER_TIMEOUT_EN
            idle_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            matrix_q <= matrix_d;
            size_q   <= size_d;
            row_q    <= row_d;
            col_q    <= col_d;
            error_q  <= error_d;
`ifdef MPU_LOADER_TIMEOUT_EN
            idle_q   <= idle_d;
`endif
        end
    end

    assign elem_ready   = (state_q == LOAD);
    assign busy         = (state_q == LOAD);
    assign matrix_valid = (state_q == DONE);
    assign matrix       = matrix_q;
    assign size         = size_q;
    assign error        = error_q;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Self-checking bench for mpu_matrix_loader: directed and randomized loads against an array model.
module tb_mpu_matrix_loader;

    localparam int DIM    = 5;
    localparam int ELEM_W = 8;
    localparam int MAT_W  = DIM * DIM * ELEM_W;

    logic                clock = 1'b0;
    logic                reset_n;
    logic                start;
    logic [7:0]          size_in;
    logic                elem_valid;
    logic [ELEM_W-1:0]   elem_data;
    logic                elem_ready;
    logic [0:MAT_W-1]    matrix;
    logic [7:0]          size;
    logic                matrix_valid;
    logic                matrix_ack;
    logic                busy;
    logic                error;

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    // Reference model: the matrix the consumer should see, as a plain 2-D array.
    logic [ELEM_W-1:0] m_mat [DIM][DIM];
    logic [7:0]        m_size;
    logic [ELEM_W-1:0] stim [$];

`ifdef MPU_LOADER_TIMEOUT_EN
    mpu_matrix_loader #(.DIM(DIM), .ELEM_W(ELEM_W), .TIMEOUT_CYCLES(4)) dut (
`else
    mpu_matrix_loader #(.DIM(DIM), .ELEM_W(ELEM_W)) dut (
`endif
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .size_in      (size_in),
        .elem_valid   (elem_valid),
        .elem_data    (elem_data),
        .elem_ready   (elem_ready),
        .matrix       (matrix),
        .size         (size),
        .matrix_valid (matrix_valid),
        .matrix_ack   (matrix_ack),
        .busy         (busy),
        .error        (error)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_mat(input string tag, input logic [0:MAT_W-1] obs, input logic [0:MAT_W-1] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:MAT_W-1] expected_matrix();
        logic [0:MAT_W-1] v;
        v = '0;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                v[(r*DIM+c)*ELEM_W +: ELEM_W] = m_mat[r][c];
        return v;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                m_mat[r][c] = '0;
        m_size = 8'd0;
    endtask

    task automatic check_held(input string tag);
        check_mat({tag, "_matrix"}, matrix, expected_matrix());
        check_byte({tag, "_size"}, size, m_size);
    endtask

    task automatic begin_load(input int n);
        start   = 1'b1;
        size_in = 8'(n);
        step();
        start   = 1'b0;
        model_clear();
        m_size = 8'(n);
        check_bit("load_busy", busy, 1'b1);
    endtask

    task automatic send_elem(input logic [ELEM_W-1:0] d, input int k, input int n);
        int guard = 0;
        while (!elem_ready && guard < 20) begin
            step();
            guard++;
        end
        check_bit("elem_ready_wait", elem_ready, 1'b1);
        elem_valid = 1'b1;
        elem_data  = d;
        m_mat[k / n][k % n] = d;
        step();
        elem_valid = 1'b0;
        elem_data  = $urandom();
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle between elements, 2 random 0..2 idle cycles
    task automatic do_load(input int n, input int gap_mode);
        begin_load(n);
        for (int k = 0; k < n * n; k++) begin
            int gaps;
            gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            if (k != 0) begin
                for (int g = 0; g < gaps; g++) step();
            end
            send_elem(stim[k], k, n);
            if (k != n * n - 1) check_bit("valid_early", matrix_valid, 1'b0);
        end
        check_bit("done_valid", matrix_valid, 1'b1);
        check_bit("done_ready", elem_ready, 1'b0);
        check_bit("done_busy", busy, 1'b0);
        check_held("done");
    endtask

    task automatic do_ack();
        matrix_ack = 1'b1;
        step();
        matrix_ack = 1'b0;
        check_bit("ack_valid", matrix_valid, 1'b0);
        check_bit("ack_busy", busy, 1'b0);
        check_held("ack_hold");
    endtask

    task automatic bad_start(input logic [7:0] s);
        start   = 1'b1;
        size_in = s;
        step();
        start   = 1'b0;
        check_bit("bad_error", error, 1'b1);
        check_bit("bad_ready", elem_ready, 1'b0);
        check_bit("bad_busy", busy, 1'b0);
        check_byte("bad_size_kept", size, m_size);
        step();
        check_bit("bad_error_pulse", error, 1'b0);
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        size_in    = 8'd0;
        elem_valid = 1'b0;
        elem_data  = '0;
        matrix_ack = 1'b0;
        model_clear();
        #12;
        check_mat("rst_matrix", matrix, '0);
        check_byte("rst_size", size, 8'd0);
        check_bit("rst_valid", matrix_valid, 1'b0);
        check_bit("rst_ready", elem_ready, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_error", error, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        step();

        $display("[TB] 2x2 back-to-back load");
        stim = '{8'd1, 8'd2, 8'd3, 8'd4};
        do_load(2, 0);
        check_byte("2x2_e00", matrix[0 +: 8], 8'd1);
        check_byte("2x2_e11", matrix[(DIM+1)*ELEM_W +: 8], 8'd4);
        for (int i = 0; i < 3; i++) begin
            step();
            check_bit("2x2_hold_valid", matrix_valid, 1'b1);
            check_held("2x2_hold");
        end
        do_ack();

        $display("[TB] 5x5 load with toggling valid");
        stim = {};
        for (int k = 1; k <= 24; k++) stim.push_back(8'(k));
        stim.push_back(8'hFF);
        do_load(5, 1);
        check_byte("5x5_e23", matrix[(2*DIM+3)*ELEM_W +: 8], 8'd14);
        check_byte("5x5_neg", matrix[(4*DIM+4)*ELEM_W +: 8], 8'hFF);

        $display("[TB] DONE hold with start noise");
        for (int i = 0; i < 10; i++) begin
            start   = i[0];
            size_in = 8'($urandom_range(1, 5));
            step();
            check_bit("hold_valid", matrix_valid, 1'b1);
            check_bit("hold_ready", elem_ready, 1'b0);
            check_held("hold");
        end
        start = 1'b1;
        do_ack();
        start = 1'b0;
        step();
        check_bit("start_at_ack_ignored", busy, 1'b0);

        $display("[TB] illegal sizes");
        bad_start(8'd0);
        bad_start(8'd6);
        bad_start(8'($urandom_range(7, 255)));

        $display("[TB] reset during load");
        begin_load(3);
        for (int k = 0; k < 4; k++) send_elem(8'($urandom()), k, 3);
        #2;
        reset_n = 1'b0;
        #1;
        model_clear();
        check_held("midrst");
        check_bit("midrst_busy", busy, 1'b0);
        check_bit("midrst_ready", elem_ready, 1'b0);
        check_bit("midrst_valid", matrix_valid, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        step();
        stim = '{8'd7};
        do_load(1, 0);
        check_byte("1x1_e00", matrix[0 +: 8], 8'd7);
        do_ack();

        $display("[TB] randomized loads");
        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, DIM);
            stim = {};
            for (int k = 0; k < n * n; k++) stim.push_back(8'($urandom()));
            do_load(n, 2);
            for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
                start   = $urandom_range(0, 1) == 1;
                size_in = 8'($urandom());
                step();
                check_held("rnd_hold");
            end
            start = 1'b0;
            do_ack();
        end

`ifdef MPU_LOADER_TIMEOUT_EN
        $display("[TB] idle timeout");
        begin_load(2);
        send_elem(8'd11, 0, 2);
        send_elem(8'd22, 1, 2);
        for (int i = 1; i <= 3; i++) begin
            step();
            check_bit("to_wait_error", error, 1'b0);
            check_bit("to_wait_busy", busy, 1'b1);
        end
        step();
        model_clear();
        check_bit("to_error", error, 1'b1);
        check_bit("to_busy", busy, 1'b0);
        check_bit("to_valid", matrix_valid, 1'b0);
        check_held("to");
        step();
        check_bit("to_error_pulse", error, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
